// File: rtl/spectrum_reader.sv
// -----------------------------------------------------------------------------
// spectrum_reader
//
// Reads one frame of magnitude words from a single-port synchronous RAM
// (1-cycle read latency) and emits it as a (valid, index, value, tlast)
// stream in address order. A 2-entry output buffer absorbs the RAM latency
// and downstream backpressure. Reads are only issued when a buffer slot is
// guaranteed, so the buffer never overflows.
//
// Ports:
//   clk        single clock
//   rst        synchronous active-high reset
//   start      one-cycle frame request (honoured in IDLE only)
//   frame_len  number of bins, 1..2^INDEX_WIDTH (0 is ignored)
//   busy       high from the cycle after an accepted start through done
//   done       one-cycle pulse after the final beat is accepted
//   ram_en     RAM read enable
//   ram_addr   RAM read address
//   ram_dout   RAM read data, valid the cycle after ram_en
//   valid      output beat valid
//   ready      downstream accepts the beat
//   index      bin number of the current beat
//   value      RAM word of the current beat
//   tlast      high on the final beat of the frame
// -----------------------------------------------------------------------------
module spectrum_reader #(
    parameter int VALUE_WIDTH = 32,
    parameter int INDEX_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INDEX_WIDTH:0]   frame_len,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_en,
    output logic [INDEX_WIDTH-1:0] ram_addr,
    input  logic [VALUE_WIDTH-1:0] ram_dout,
    output logic                   valid,
    input  logic                   ready,
    output logic [INDEX_WIDTH-1:0] index,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   tlast
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH:0] CNT_ONE = {{INDEX_WIDTH{1'b0}}, 1'b1};

    state_t state_reg, state_next;

    // Counters are one bit wider than the address so a full 2^INDEX_WIDTH
    // frame can be counted without wrapping back to zero.
    logic [INDEX_WIDTH:0]   len_reg;
    logic [INDEX_WIDTH:0]   rd_cnt_reg;
    logic [INDEX_WIDTH:0]   out_cnt_reg;
    logic                   inflight_reg;
    logic [1:0]             count_reg;
    logic                   wr_ptr_reg;
    logic                   rd_ptr_reg;
    logic [VALUE_WIDTH-1:0] mem_reg [2];

    logic       accept_start;
    logic       pop;
    logic       push;
    logic [2:0] credit_used;
    logic [1:0] wr_sel;

    assign accept_start = (state_reg == S_IDLE) && start && (frame_len != '0);

    assign valid = (count_reg != 2'd0);
    assign pop   = valid && ready;
    assign push  = inflight_reg;          // RAM data lands one cycle after ram_en
    assign value = mem_reg[rd_ptr_reg];
    assign index = out_cnt_reg[INDEX_WIDTH-1:0];
    assign tlast = valid && (out_cnt_reg == len_reg - CNT_ONE);

    // Slots already spoken for after this cycle's pop: buffered words plus
    // the read whose data arrives next cycle. A new read needs a free slot.
    assign credit_used = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

    assign ram_en   = (state_reg == S_RUN) && (rd_cnt_reg < len_reg) && (credit_used < 3'd2);
    assign ram_addr = rd_cnt_reg[INDEX_WIDTH-1:0];

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);

    // Per-slot write select for the output buffer
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept_start) state_next = S_RUN;
            S_RUN:  if (pop && tlast) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            len_reg      <= '0;
            rd_cnt_reg   <= '0;
            out_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            inflight_reg <= ram_en;
            if (accept_start) begin
                len_reg     <= frame_len;
                rd_cnt_reg  <= '0;
                out_cnt_reg <= '0;
                count_reg   <= 2'd0;
                wr_ptr_reg  <= 1'b0;
                rd_ptr_reg  <= 1'b0;
            end else begin
                if (ram_en) begin
                    rd_cnt_reg <= rd_cnt_reg + CNT_ONE;
                end
                if (pop) begin
                    out_cnt_reg <= out_cnt_reg + CNT_ONE;
                    rd_ptr_reg  <= ~rd_ptr_reg;
                end
                if (push) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + 2'd1;
                    2'b01:   count_reg <= count_reg - 2'd1;
                    default: count_reg <= count_reg;
                endcase
                for (int i = 0; i < 2; i++) begin
                    if (wr_sel[i]) begin
                        mem_reg[i] <= ram_dout;
                    end
                end
            end
        end
    end

endmodule
